// File: rtl/pipelined_rca_adder_pkg.sv
// -----------------------------------------------------------------------------
// pipelined_rca_adder_pkg
//   Shared definitions for the pipelined ripple-carry adder:
//   - DEFAULT_WIDTH / DEFAULT_STAGES : default operand width and stage count
//   - ceil_div()                     : integer ceiling divide, used to size
//                                      the per-stage segment width
// -----------------------------------------------------------------------------
package pipelined_rca_adder_pkg;

    localparam int DEFAULT_WIDTH  = 23;
    localparam int DEFAULT_STAGES = 4;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/pipelined_rca_adder_rca_segment.sv
// -----------------------------------------------------------------------------
// rca_segment
//   Combinational N-bit ripple-carry adder built from explicit full-adder
//   equations (no '+' operator).
//   Ports:
//     a, b [N-1:0] : addends
//     ci           : carry in to bit 0
//     s    [N-1:0] : sum bits
//     co           : carry out of bit N-1
// -----------------------------------------------------------------------------
module rca_segment
    import pipelined_rca_adder_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N-1:0] s,
    output logic         co
);

    logic carry;

    // NOTE: blocking assignments are correct here; 'carry' is a combinational
    // temporary that must update in program order as it ripples up the chain.
    always_comb begin
        carry = ci;
        s     = '0;
        for (int i = 0; i < N; i++) begin
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | ((a[i] ^ b[i]) & carry);
        end
        co = carry;
    end

endmodule

// File: rtl/pipelined_rca_adder.sv
// -----------------------------------------------------------------------------
// pipelined_rca_adder
//   Unsigned add/subtract with a valid/ready pipelined ripple-carry datapath.
//   The operand is split into STAGES segments (low to high); stage k ripples
//   segment k-1 using the carry registered by the stage before it.
//     SUB=0 : S = X + Y + CIN
//     SUB=1 : S = X + ~Y + 1   (S[WIDTH] = no-borrow)
//   Ports:
//     CLK       : clock, all registers on the rising edge
//     RST       : synchronous active-high reset, flushes every in-flight beat
//     IN_VALID  : operand beat offered
//     IN_READY  : beat accepted this cycle (combinational from OUT_READY)
//     X, Y      : operands [WIDTH-1:0]
//     CIN       : carry-in for add; ignored for subtract
//     SUB       : 1 selects subtract
//     OUT_VALID : result beat offered
//     OUT_READY : downstream accepts the result
//     S         : result [WIDTH:0], S[WIDTH] = carry out / no-borrow
// -----------------------------------------------------------------------------
module pipelined_rca_adder
    import pipelined_rca_adder_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             CIN,
    input  logic             SUB,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH:0]   S
);

    localparam int SEG = ceil_div(WIDTH, STAGES);

    // Stage registers, index k = 1..STAGES. Operands are carried full width;
    // bits already consumed by earlier stages have no reader and are pruned
    // by synthesis, leaving only the still-unprocessed bits per stage.
    logic [STAGES:1]            v_q;
    logic [STAGES:1]            c_q;
    logic [STAGES:1][WIDTH-1:0] x_q;
    logic [STAGES:1][WIDTH-1:0] y_q;
    logic [STAGES:1][WIDTH-1:0] s_q;

    // What each stage sees at its input: the external beat for stage 1,
    // the previous stage's registers otherwise.
    logic [STAGES:1]            v_src;
    logic [STAGES:1]            c_src;
    logic [STAGES:1][WIDTH-1:0] x_src;
    logic [STAGES:1][WIDTH-1:0] y_src;
    logic [STAGES:1][WIDTH-1:0] s_src;

    // Values a stage will capture after rippling its own segment.
    logic [STAGES:1]            c_nxt;
    logic [STAGES:1][WIDTH-1:0] s_nxt;

    // rdy[k]: stage k may load this cycle. rdy[STAGES+1] is the downstream.
    logic [STAGES+1:1]          rdy;

    always_comb begin
        v_src    = '0;
        c_src    = '0;
        x_src    = '0;
        y_src    = '0;
        s_src    = '0;
        v_src[1] = IN_VALID;
        x_src[1] = X;
        y_src[1] = SUB ? ~Y : Y;
        c_src[1] = SUB | CIN;
        for (int k = 2; k <= STAGES; k++) begin
            v_src[k] = v_q[k-1];
            c_src[k] = c_q[k-1];
            x_src[k] = x_q[k-1];
            y_src[k] = y_q[k-1];
            s_src[k] = s_q[k-1];
        end
    end

    // A stage can take new data if it is empty or its content moves on this
    // same cycle; evaluating from the output backwards lets bubbles collapse
    // behind a stalled stage.
    always_comb begin
        rdy           = '0;
        rdy[STAGES+1] = OUT_READY;
        for (int k = STAGES; k >= 1; k--) begin
            rdy[k] = !v_q[k] || rdy[k+1];
        end
    end

    for (genvar k = 1; k <= STAGES; k++) begin : g_stage
        localparam int LO = (k - 1) * SEG;
        localparam int HI = (k * SEG < WIDTH) ? k * SEG : WIDTH;
        localparam int W  = (HI > LO) ? HI - LO : 0;

        if (W > 0) begin : g_seg
            // Keep the sum bits produced below this segment, replace the rest.
            localparam logic [WIDTH-1:0] LOW_MASK = (WIDTH'(1) << LO) - WIDTH'(1);
            logic [W-1:0] seg_sum;

            rca_segment #(.N(W)) u_rca (
                .a  (x_src[k][LO +: W]),
                .b  (y_src[k][LO +: W]),
                .ci (c_src[k]),
                .s  (seg_sum),
                .co (c_nxt[k])
            );

            assign s_nxt[k] = (s_src[k] & LOW_MASK) | (WIDTH'(seg_sum) << LO);
        end else begin : g_pass
            // Ceiling split can leave trailing stages with no bits: they
            // only delay the beat so latency stays equal to STAGES.
            assign s_nxt[k] = s_src[k];
            assign c_nxt[k] = c_src[k];
        end
    end

    // NOTE: the datapath registers are reset along with the valids because
    // S must read zero while in reset; an invalid stage's data is otherwise
    // never observed.
    always_ff @(posedge CLK) begin
        if (RST) begin
            v_q <= '0;
            c_q <= '0;
            x_q <= '0;
            y_q <= '0;
            s_q <= '0;
        end else begin
            for (int k = 1; k <= STAGES; k++) begin
                if (rdy[k]) begin
                    v_q[k] <= v_src[k];
                    if (v_src[k]) begin
                        c_q[k] <= c_nxt[k];
                        x_q[k] <= x_src[k];
                        y_q[k] <= y_src[k];
                        s_q[k] <= s_nxt[k];
                    end
                end
            end
        end
    end

    // Already-consumed operand bits and the last stage's operands have no
    // reader; collecting them here marks that as intentional.
    logic unused_operand_bits;
    assign unused_operand_bits = ^{x_q, y_q, x_src, y_src};

    assign IN_READY  = rdy[1];
    assign OUT_VALID = v_q[STAGES];
    assign S         = {c_q[STAGES], s_q[STAGES]};

endmodule

// File: tb/tb_pipelined_rca_adder.sv
`timescale 1ns/1ps
module tb_pipelined_rca_adder;

    localparam int W  = 23;
    localparam int ST = 4;
    localparam int NV = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;

    // 23-bit / 4-stage main instance
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] x = '0;
    logic [W-1:0] y = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W:0]   s;

    // 8-bit sweep instances: index 0 -> STAGES=1, index 1 -> STAGES=8
    logic       iv8   [2];
    logic       ir8   [2];
    logic [7:0] x8    [2];
    logic [7:0] y8    [2];
    logic       cin8  [2];
    logic       sub8  [2];
    logic       ov8   [2];
    logic       ordy8 [2];
    logic [8:0] s8    [2];

    pipelined_rca_adder #(.WIDTH(W), .STAGES(ST)) u_dut (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready),
        .X(x), .Y(y), .CIN(cin), .SUB(sub),
        .OUT_VALID(out_valid), .OUT_READY(out_ready), .S(s)
    );

    pipelined_rca_adder #(.WIDTH(8), .STAGES(1)) u_w8s1 (
        .CLK(clk), .RST(rst), .IN_VALID(iv8[0]), .IN_READY(ir8[0]),
        .X(x8[0]), .Y(y8[0]), .CIN(cin8[0]), .SUB(sub8[0]),
        .OUT_VALID(ov8[0]), .OUT_READY(ordy8[0]), .S(s8[0])
    );

    pipelined_rca_adder #(.WIDTH(8), .STAGES(8)) u_w8s8 (
        .CLK(clk), .RST(rst), .IN_VALID(iv8[1]), .IN_READY(ir8[1]),
        .X(x8[1]), .Y(y8[1]), .CIN(cin8[1]), .SUB(sub8[1]),
        .OUT_VALID(ov8[1]), .OUT_READY(ordy8[1]), .S(s8[1])
    );

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         cin;
        logic         sub;
        logic [W:0]   exp_s;
    } vec_t;

    typedef struct {
        logic [W:0] exp;
        int         acc;
    } sb_t;

    typedef struct {
        logic [8:0] exp;
        int         acc;
    } sb8_t;

    vec_t vecs [NV];
    sb_t  sb  [$];
    sb8_t sb8 [$];

    int checks    = 0;
    int errors    = 0;
    int cyc       = 0;
    int delivered = 0;
    int del8      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference for the 8-bit sweep, written as plain subtraction so it is
    // independent of the invert-and-add-one form used in hardware.
    function automatic logic [8:0] ref8(input logic [7:0] a, input logic [7:0] b,
                                        input logic c, input logic sb_op);
        if (sb_op) return 9'(a) + 9'd256 - 9'(b);
        return 9'(a) + 9'(b) + 9'(c);
    endfunction

    // One cycle on the main instance: drive at negedge, sample 1ns later,
    // then let the rising edge perform the handshake.
    task automatic step(input logic iv, input logic [W-1:0] ix, input logic [W-1:0] iy,
                        input logic icin, input logic isub, input logic [W:0] iexp,
                        input logic ordy, input bit chk_lat,
                        output logic acc, output logic rdy_o, output logic ov, output logic [W:0] sv);
        sb_t e;
        @(negedge clk);
        in_valid = iv; x = ix; y = iy; cin = icin; sub = isub; out_ready = ordy;
        #1;
        acc   = iv && in_ready;
        rdy_o = in_ready;
        ov    = out_valid;
        sv    = s;
        if (out_valid && ordy) begin
            check("unexpected_result", sb.size() == 0, 0);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                delivered++;
                check("sum", s, e.exp);
                if (chk_lat) check("latency", cyc - e.acc, ST);
            end
        end
        if (acc) begin
            e.exp = iexp;
            e.acc = cyc;
            sb.push_back(e);
        end
        @(posedge clk);
    endtask

    task automatic drain(input int max_cycles, input bit chk_lat);
        logic acc, r, ov;
        logic [W:0] sv;
        int guard = 0;
        while (sb.size() != 0 && guard < max_cycles) begin
            step(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1, chk_lat, acc, r, ov, sv);
            guard++;
        end
        check("drain_empty", sb.size(), 0);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 2; i++) iv8[i] = 1'b0;
        repeat (n) @(posedge clk);
        sb.delete();
        sb8.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_s", s, 0);
        check("reset_in_ready", in_ready, 1);
    endtask

    task automatic step8(input int idx, input logic iv, input logic [7:0] ix, input logic [7:0] iy,
                         input logic icin, input logic isub, input logic ordy, input int exp_lat,
                         output logic acc);
        sb8_t e;
        @(negedge clk);
        iv8[idx] = iv; x8[idx] = ix; y8[idx] = iy; cin8[idx] = icin; sub8[idx] = isub;
        ordy8[idx] = ordy;
        #1;
        acc = iv && ir8[idx];
        if (ov8[idx] && ordy) begin
            check("sweep_unexpected_result", sb8.size() == 0, 0);
            if (sb8.size() != 0) begin
                e = sb8.pop_front();
                del8++;
                check($sformatf("sweep%0d_sum", idx), s8[idx], e.exp);
                if (exp_lat > 0) check($sformatf("sweep%0d_latency", idx), cyc - e.acc, exp_lat);
            end
        end
        if (acc) begin
            e.exp = ref8(ix, iy, icin, isub);
            e.acc = cyc;
            sb8.push_back(e);
        end
        @(posedge clk);
    endtask

    task automatic sweep(input int idx, input int lat);
        logic acc;
        int   n;
        int   guard;
        int   del_base;
        del_base = del8;
        step8(idx, 1'b1, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b1, lat, acc);
        check("sweep_first_accept", acc, 1);
        guard = 0;
        while (sb8.size() != 0 && guard < 20) begin
            step8(idx, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, lat, acc);
            guard++;
        end
        check("sweep_first_delivered", sb8.size(), 0);
        n = 0;
        guard = 0;
        while (n < 1000 && guard < 20000) begin
            step8(idx, ($urandom_range(3, 0) != 0), 8'($urandom), 8'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), 0, acc);
            if (acc) n++;
            guard++;
        end
        check("sweep_beats_accepted", n, 1000);
        guard = 0;
        while (sb8.size() != 0 && guard < 100) begin
            step8(idx, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 0, acc);
            guard++;
        end
        check("sweep_drain_empty", sb8.size(), 0);
        check("sweep_delivered_count", del8 - del_base, 1001);
    endtask

    initial begin
        logic       acc, r, ov;
        logic [W:0] sv;
        int         b;
        int         del_base;

        vecs[0]  = '{23'h7FFFFF, 23'h000001, 1'b0, 1'b0, 24'h800000};
        vecs[1]  = '{23'h000005, 23'h000007, 1'b0, 1'b1, 24'h7FFFFE};
        vecs[2]  = '{23'h000007, 23'h000005, 1'b0, 1'b1, 24'h800002};
        vecs[3]  = '{23'h7FFFFF, 23'h000000, 1'b1, 1'b0, 24'h800000};
        vecs[4]  = '{23'h000000, 23'h000000, 1'b0, 1'b0, 24'h000000};
        vecs[5]  = '{23'h123456, 23'h654321, 1'b0, 1'b0, 24'h777777};
        vecs[6]  = '{23'h7FFFFF, 23'h7FFFFF, 1'b1, 1'b0, 24'hFFFFFF};
        vecs[7]  = '{23'h000100, 23'h000100, 1'b1, 1'b1, 24'h800000};
        vecs[8]  = '{23'h000000, 23'h000001, 1'b0, 1'b1, 24'h7FFFFF};
        vecs[9]  = '{23'h2AAAAA, 23'h555555, 1'b0, 1'b0, 24'h7FFFFF};
        vecs[10] = '{23'h400000, 23'h400001, 1'b1, 1'b0, 24'h800002};
        vecs[11] = '{23'h3C3C3C, 23'h0F0F0F, 1'b1, 1'b0, 24'h4B4B4C};

        for (int i = 0; i < 2; i++) begin
            iv8[i] = 1'b0; x8[i] = '0; y8[i] = '0; cin8[i] = 1'b0; sub8[i] = 1'b0; ordy8[i] = 1'b0;
        end

        do_reset(2);

        // Single beats into an empty pipe: value and exact latency.
        for (int i = 0; i < NV; i++) begin
            step(1'b1, vecs[i].x, vecs[i].y, vecs[i].cin, vecs[i].sub, vecs[i].exp_s,
                 1'b1, 1'b1, acc, r, ov, sv);
            check($sformatf("vec%0d_accept", i), acc, 1);
            drain(10, 1'b1);
        end

        // Back-to-back beats with OUT_READY low in cycles 3..6.
        del_base = delivered;
        b = 0;
        for (int c = 0; c < 16; c++) begin
            if (b < 8)
                step(1'b1, vecs[b].x, vecs[b].y, vecs[b].cin, vecs[b].sub, vecs[b].exp_s,
                     !(c >= 3 && c <= 6), 1'b0, acc, r, ov, sv);
            else
                step(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0, acc, r, ov, sv);
            if (acc) b++;
            if (c <= 3) check("bp_in_ready_free", r, 1);
            if (c >= 4 && c <= 6) begin
                check("bp_in_ready_full", r, 0);
                check("bp_hold_valid", ov, 1);
                check("bp_hold_s", sv, vecs[0].exp_s);
            end
        end
        check("bp_all_accepted", b, 8);
        drain(20, 1'b0);
        check("bp_delivered_count", delivered - del_base, 8);

        // Reset with three beats in flight.
        for (int i = 0; i < 3; i++)
            step(1'b1, vecs[i].x, vecs[i].y, vecs[i].cin, vecs[i].sub, vecs[i].exp_s,
                 1'b1, 1'b0, acc, r, ov, sv);
        check("rst_inflight", sb.size(), 3);
        do_reset(1);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0, acc, r, ov, sv);
            check("rst_no_stale", ov, 0);
        end
        step(1'b1, vecs[5].x, vecs[5].y, vecs[5].cin, vecs[5].sub, vecs[5].exp_s,
             1'b1, 1'b1, acc, r, ov, sv);
        check("rst_new_accept", acc, 1);
        drain(10, 1'b1);

        @(negedge clk);
        in_valid = 1'b0;

        // 8-bit parameter sweep.
        sweep(0, 1);
        sweep(1, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipelined_rca_adder.md
PIPELINED_RCA_ADDER -- requirements
Module: pipelined_rca_adder

Interface
REQ-001 Parameter WIDTH, default 23: operand width in bits; legal range 2..64.
REQ-002 Parameter STAGES, default 4: number of pipeline stages; legal range 1..WIDTH.
REQ-003 Port CLK, input, 1: the single clock; every register samples on its rising edge.
REQ-004 Port RST, input, 1: reset; synchronous, active-high.
REQ-005 Port IN_VALID, input, 1: operand beat offered.
REQ-006 Port IN_READY, output, 1: the block accepts a beat this cycle.
REQ-007 Port X, input, WIDTH: operand 1, unsigned.
REQ-008 Port Y, input, WIDTH: operand 2, unsigned.
REQ-009 Port CIN, input, 1: carry-in, used only for add.
REQ-010 Port SUB, input, 1: 0 = X+Y+CIN, 1 = X-Y.
REQ-011 Port OUT_VALID, output, 1: result beat offered.
REQ-012 Port OUT_READY, input, 1: downstream accepts the result.
REQ-013 Port S, output, WIDTH+1: result; S[WIDTH] is carry-out, or no-borrow when SUB=1.

Function
REQ-014 Beat accepted on an edge with IN_VALID && IN_READY; result delivered on an edge with OUT_VALID && OUT_READY.
REQ-015 Effective operands: Y' = SUB ? ~Y : Y; c0 = SUB ? 1 : CIN; S = X + Y' + c0, computed at WIDTH+1 bits.
REQ-016 Bits are split into STAGES segments, low to high; segment width SEG = ceil(WIDTH/STAGES); the last segment takes the remaining bits.
REQ-017 Stage k (1..STAGES) ripples segment k-1 using the carry registered by stage k-1.
REQ-018 Stage k registers: sum bits so far, carry, still-unprocessed X/Y' bits, and a valid bit.
REQ-019 Latency: exactly STAGES cycles from acceptance to OUT_VALID when not stalled.
REQ-020 Throughput: one beat per cycle when OUT_READY is held high.
REQ-021 Stage k loads when it is empty or stage k+1 (or the output, for the last stage) drains it in the same cycle.
REQ-022 IN_READY = !valid[1] || stage 1 drains this cycle; the path is combinational from OUT_READY.
REQ-023 Full pipeline with OUT_READY low: IN_READY is low in the same cycle; nothing is lost or overwritten.
REQ-024 Bubbles collapse: an empty stage loads even while a later stage is stalled.
REQ-025 While OUT_VALID && !OUT_READY, S is held stable.
REQ-026 Full pipeline with OUT_READY=1 and IN_VALID=1: one result leaves and one beat enters in the same cycle.
REQ-027 Results leave in acceptance order; there are no duplicates and no drops.
REQ-028 Carry wrap: S[WIDTH] is the true carry out of bit WIDTH-1; no saturation.

Reset
REQ-029 With RST high at an edge: all stage valids clear to 0, OUT_VALID is 0, S is 0, and every in-flight beat is discarded.
REQ-030 IN_READY is 1 in the first cycle after RST deasserts.
REQ-031 Reset asserted mid-operation: no result from before the reset is ever delivered.

Structure
REQ-032 A shared package holds the default WIDTH and STAGES, and a ceil-divide function for SEG.
REQ-033 One sub-module, rca_segment: a parametrised combinational full-adder ripple chain with carry in and carry out; the top level instantiates it once per stage.
REQ-034 No arithmetic operator inference in rca_segment: explicit full-adder bit equations only.

Verification (WIDTH=23, STAGES=4 unless stated)
REQ-035 Add overflow: X=0x7FFFFF, Y=0x000001, CIN=0, SUB=0, OUT_READY=1 -> S=0x800000, OUT_VALID exactly 4 cycles after acceptance.
REQ-036 Subtract with borrow: X=0x000005, Y=0x000007, SUB=1 -> S=0x7FFFFE (S[23]=0); X=7, Y=5, SUB=1 -> S=0x800002.
REQ-037 Full carry chain: X=0x7FFFFF, Y=0, CIN=1 -> S=0x800000, so the carry crosses all 4 segments.
REQ-038 Backpressure: 8 back-to-back beats with OUT_READY low for cycles 3-6 -> IN_READY low once 4 beats are held; all 8 results arrive in order, correct, each exactly once.
REQ-039 Reset mid-stream: 3 beats in flight, RST high for 1 cycle -> OUT_VALID=0 next cycle, no stale result later, and a new beat returns its correct sum after 4 cycles.
REQ-040 Parameter sweep: WIDTH=8 with STAGES=1 gives latency 1; WIDTH=8 with STAGES=8 gives latency 8; 1000 random beats with random OUT_READY match a reference model.
